// File: rtl/bram_dp_dump.sv
// bram_dp_dump: dual-port block RAM (port A byte-write r/w, port B read-only) with a valid/ready engine that streams out the whole array
module bram_dp_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS = 9,
  parameter int READ_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_BITS-1:0]    a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic                    b_en,
  input  logic [ADDR_BITS-1:0]    b_addr,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid,
  input  logic                    dump_start,
  output logic                    dump_busy,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [ADDR_BITS-1:0]    dump_addr,
  output logic [DATA_WIDTH-1:0]   dump_data,
  output logic                    dump_done
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int LAT = 1 + OUT_REG;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_new, a_word, b_word, a_s1, a_s2, b_s1, b_s2, e_s1, e_s2;
  logic a_v1, a_v2, b_v1, b_v2, b_req, cnt;
  logic [ADDR_BITS-1:0] ptr;

  always_comb begin
    a_new = mem[a_addr];
    for (int i = 0; i < NB; i++)
      a_new[8*i +: 8] = a_we[i] ? a_wdata[8*i +: 8] : a_new[8*i +: 8];
  end

  assign a_word = READ_MODE != 0 ? a_new : mem[a_addr];
  assign b_req = b_en && !dump_busy;
  assign b_word = mem[dump_busy ? ptr : b_addr];

  always_ff @(posedge clock)
    for (int i = 0; i < NB; i++)
      if (a_en && a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a_v1 <= 1'b0;
      a_v2 <= 1'b0;
      b_v1 <= 1'b0;
      b_v2 <= 1'b0;
      a_s1 <= '0;
      a_s2 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
      e_s1 <= '0;
      e_s2 <= '0;
    end else begin
      a_v1 <= a_en;
      a_v2 <= a_v1;
      b_v1 <= b_req;
      b_v2 <= b_v1;
      if (a_en) a_s1 <= a_word;
      if (b_req) b_s1 <= b_word;
      if (state == ISSUE) e_s1 <= b_word;
      if (a_v1) a_s2 <= a_s1;
      if (b_v1) b_s2 <= b_s1;
      e_s2 <= e_s1;
    end

  assign a_rdata = OUT_REG != 0 ? a_s2 : a_s1;
  assign a_rvalid = OUT_REG != 0 ? a_v2 : a_v1;
  assign b_rdata = OUT_REG != 0 ? b_s2 : b_s1;
  assign b_rvalid = OUT_REG != 0 ? b_v2 : b_v1;
  assign dump_data = OUT_REG != 0 ? e_s2 : e_s1;
  assign dump_addr = ptr;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= 1'b0;
      dump_busy <= 1'b0;
      dump_valid <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE:
          if (dump_start) begin
            state <= ISSUE;
            ptr <= '0;
            dump_busy <= 1'b1;
          end
        ISSUE: begin
          state <= WAIT;
          cnt <= 1'b0;
        end
        WAIT:
          if (cnt == 1'(LAT - 1)) begin
            state <= PRESENT;
            dump_valid <= 1'b1;
          end else cnt <= cnt + 1'b1;
        PRESENT:
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (ptr == ADDR_BITS'(DEPTH - 1)) begin
              state <= DONE;
              dump_done <= 1'b1;
              dump_busy <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
              state <= ISSUE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bram_dp_dump.sv
// tb_bram_dp_dump: table-driven port checks on read-first/no-outreg and write-first/outreg instances plus dump engine sequences
module tb_bram_dp_dump;
  logic clk = 1'b0, reset = 1'b1, a_en = 1'b0, b_en = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [3:0] a_we = '0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [31:0] a_rdata0, b_rdata0, dump_data0, a_rdata1, b_rdata1, dump_data1;
  logic a_rvalid0, b_rvalid0, dump_busy0, dump_valid0, dump_done0;
  logic a_rvalid1, b_rvalid1, dump_busy1, dump_valid1, dump_done1;
  logic [2:0] dump_addr0, dump_addr1;
  int checks = 0, errors = 0;
  typedef struct {
    logic a_en; logic [3:0] a_we; logic [2:0] a_addr; logic [31:0] a_wdata; logic b_en; logic [2:0] b_addr;
    logic av0; logic [31:0] ad0; logic bv0; logic [31:0] bd0;
    logic av1; logic [31:0] ad1; logic bv1; logic [31:0] bd1;
  } vec_t;
  vec_t v[14];

  always #5 clk = ~clk;

  bram_dp_dump #(.DATA_WIDTH(32), .ADDR_BITS(3), .READ_MODE(0), .OUT_REG(0)) u0 (
    .clock(clk), .reset(reset), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0), .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata0),
    .b_rvalid(b_rvalid0), .dump_start(dump_start), .dump_busy(dump_busy0), .dump_valid(dump_valid0),
    .dump_ready(dump_ready), .dump_addr(dump_addr0), .dump_data(dump_data0), .dump_done(dump_done0));

  bram_dp_dump #(.DATA_WIDTH(32), .ADDR_BITS(3), .READ_MODE(1), .OUT_REG(1)) u1 (
    .clock(clk), .reset(reset), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1), .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1),
    .b_rvalid(b_rvalid1), .dump_start(dump_start), .dump_busy(dump_busy1), .dump_valid(dump_valid1),
    .dump_ready(dump_ready), .dump_addr(dump_addr1), .dump_data(dump_data1), .dump_done(dump_done1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    a_en = 1'b1;
    a_we = 4'hF;
    a_addr = addr;
    a_wdata = data;
    @(posedge clk);
    #1;
    a_en = 1'b0;
    a_we = '0;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) wr(3'(i), 32'(i * 16));
  endtask

  task automatic dump_check(input bit extra);
    int beats = 0, dones = 0, acc_c = -1, done_c = -2;
    bit stall = 0, pulsed = 0;
    logic [2:0] pa = '0;
    logic [31:0] pd = '0;
    b_en = 1'b0;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    chk("busy_after_start", 32'(dump_busy0), 32'd1);
    for (int c = 0; c < 80; c++) begin
      dump_ready = c[0];
      b_en = 1'b1;
      b_addr = c[2:0];
      dump_start = extra && beats == 2 && !pulsed;
      if (dump_start) pulsed = 1;
      if (dump_busy0) chk("b_rvalid_dump", 32'(b_rvalid0), 32'd0);
      if (dump_done0) begin
        dones++;
        done_c = c;
      end
      if (stall) begin
        chk("stall_valid", 32'(dump_valid0), 32'd1);
        chk("stall_addr", 32'(dump_addr0), 32'(pa));
        chk("stall_data", dump_data0, pd);
      end
      if (dump_valid0 && dump_ready) begin
        chk("beat_addr", 32'(dump_addr0), 32'(beats));
        chk("beat_data", dump_data0, 32'(beats * 16));
        beats++;
        if (beats == 8) acc_c = c;
      end
      stall = dump_valid0 && !dump_ready;
      pa = dump_addr0;
      pd = dump_data0;
      @(posedge clk);
      #1;
    end
    b_en = 1'b0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    chk("beat_count", 32'(beats), 32'd8);
    chk("done_count", 32'(dones), 32'd1);
    chk("done_timing", 32'(done_c), 32'(acc_c + 1));
    chk("busy_end", 32'(dump_busy0), 32'd0);
    chk("valid_end", 32'(dump_valid0), 32'd0);
  endtask

  initial begin
    bit found = 0;
    v[0]  = '{1'b1, 4'hF, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 1'b1, 32'h00000050, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    v[1]  = '{1'b1, 4'h1, 3'd5, 32'h000000AA, 1'b0, 3'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'hDEADBEAA, 1'b0, 32'h0};
    v[2]  = '{1'b1, 4'h0, 3'd5, 32'h00000000, 1'b0, 3'd0, 1'b1, 32'hDEADBEAA, 1'b0, 32'h0, 1'b1, 32'hDEADBEAA, 1'b0, 32'h0};
    v[3]  = '{1'b0, 4'h0, 3'd0, 32'h00000000, 1'b0, 3'd0, 1'b0, 32'hDEADBEAA, 1'b0, 32'h0, 1'b0, 32'hDEADBEAA, 1'b0, 32'h0};
    v[4]  = '{1'b1, 4'hF, 3'd3, 32'h11111111, 1'b0, 3'd0, 1'b1, 32'h00000030, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0, 32'h0};
    v[5]  = '{1'b1, 4'hF, 3'd3, 32'h22222222, 1'b0, 3'd0, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b1, 32'h22222222, 1'b0, 32'h0};
    v[6]  = '{1'b1, 4'hF, 3'd7, 32'h00000044, 1'b0, 3'd0, 1'b1, 32'h00000070, 1'b0, 32'h0, 1'b1, 32'h00000044, 1'b0, 32'h0};
    v[7]  = '{1'b1, 4'hF, 3'd7, 32'h00000055, 1'b1, 3'd7, 1'b1, 32'h00000044, 1'b1, 32'h44, 1'b1, 32'h00000055, 1'b1, 32'h44};
    v[8]  = '{1'b0, 4'h0, 3'd0, 32'h00000000, 1'b1, 3'd7, 1'b0, 32'h00000044, 1'b1, 32'h55, 1'b0, 32'h00000055, 1'b1, 32'h55};
    v[9]  = '{1'b1, 4'hC, 3'd3, 32'hAABBCCDD, 1'b1, 3'd5, 1'b1, 32'h22222222, 1'b1, 32'hDEADBEAA, 1'b1, 32'hAABB2222, 1'b1, 32'hDEADBEAA};
    v[10] = '{1'b1, 4'h0, 3'd3, 32'h00000000, 1'b1, 3'd3, 1'b1, 32'hAABB2222, 1'b1, 32'hAABB2222, 1'b1, 32'hAABB2222, 1'b1, 32'hAABB2222};
    v[11] = '{1'b0, 4'h0, 3'd0, 32'h00000000, 1'b0, 3'd0, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222};
    v[12] = '{1'b0, 4'hF, 3'd3, 32'h00000000, 1'b0, 3'd0, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222, 1'b0, 32'hAABB2222};
    v[13] = '{1'b1, 4'h0, 3'd3, 32'h00000000, 1'b0, 3'd0, 1'b1, 32'hAABB2222, 1'b0, 32'hAABB2222, 1'b1, 32'hAABB2222, 1'b0, 32'hAABB2222};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rdata", a_rdata0, 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid0), 32'd0);
    chk("rst_b_rdata", b_rdata0, 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid0), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid0), 32'd0);
    chk("rst_dump_busy", 32'(dump_busy0), 32'd0);
    chk("rst_dump_done", 32'(dump_done0), 32'd0);
    chk("rst_dump_addr", 32'(dump_addr0), 32'd0);
    chk("rst_dump_data", dump_data0, 32'h0);
    chk("rst_a_rdata_u1", a_rdata1, 32'h0);
    reset = 1'b0;
    preload();
    for (int i = 0; i < 14; i++) begin
      a_en = v[i].a_en;
      a_we = v[i].a_we;
      a_addr = v[i].a_addr;
      a_wdata = v[i].a_wdata;
      b_en = v[i].b_en;
      b_addr = v[i].b_addr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_rvalid0", i), 32'(a_rvalid0), 32'(v[i].av0));
      chk($sformatf("v%0d_a_rdata0", i), a_rdata0, v[i].ad0);
      chk($sformatf("v%0d_b_rvalid0", i), 32'(b_rvalid0), 32'(v[i].bv0));
      chk($sformatf("v%0d_b_rdata0", i), b_rdata0, v[i].bd0);
      if (i > 0) begin
        chk($sformatf("v%0d_a_rvalid1", i - 1), 32'(a_rvalid1), 32'(v[i-1].av1));
        chk($sformatf("v%0d_a_rdata1", i - 1), a_rdata1, v[i-1].ad1);
        chk($sformatf("v%0d_b_rvalid1", i - 1), 32'(b_rvalid1), 32'(v[i-1].bv1));
        chk($sformatf("v%0d_b_rdata1", i - 1), b_rdata1, v[i-1].bd1);
      end
    end
    a_en = 1'b0;
    a_we = '0;
    b_en = 1'b0;
    @(posedge clk);
    #1;
    chk("v13_a_rvalid1", 32'(a_rvalid1), 32'(v[13].av1));
    chk("v13_a_rdata1", a_rdata1, v[13].ad1);
    chk("v13_b_rvalid1", 32'(b_rvalid1), 32'(v[13].bv1));
    chk("v13_b_rdata1", b_rdata1, v[13].bd1);
    preload();
    dump_check(0);
    repeat (30) @(posedge clk);
    #1;
    a_en = 1'b1;
    a_we = '0;
    a_addr = 3'd1;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (dump_valid0 && dump_addr0 == 3'd3) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    dump_ready = 1'b0;
    a_en = 1'b0;
    chk("find_word3", 32'(found), 32'd1);
    chk("pre_rst_a_rvalid", 32'(a_rvalid0), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(dump_valid0), 32'd0);
    chk("mid_rst_busy", 32'(dump_busy0), 32'd0);
    chk("mid_rst_a_rvalid", 32'(a_rvalid0), 32'd0);
    chk("mid_rst_addr", 32'(dump_addr0), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_done", 32'(dump_done0), 32'd0);
    reset = 1'b0;
    dump_check(0);
    repeat (30) @(posedge clk);
    #1;
    dump_check(1);
    repeat (30) @(posedge clk);
    #1;
    chk("u1_busy_end", 32'(dump_busy1), 32'd0);
    chk("u1_valid_end", 32'(dump_valid1), 32'd0);
    chk("u1_done_end", 32'(dump_done1), 32'd0);
    chk("u1_last_addr", 32'(dump_addr1), 32'd7);
    chk("u1_last_data", dump_data1, 32'h70);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_dp_dump.md
Name: bram_dp_dump

Overview:
- Parametrised successor to the team's single-port block RAM, inferred as block RAM.
- Port A: read/write with per-byte write enables and selectable read-first/write-first behaviour.
- Port B: read-only.
- Built-in dump engine streams the whole array out over a valid/ready interface on request, replacing the ad-hoc end-of-simulation file dump with synthesizable hardware.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_BITS, 9, address width; DEPTH = 2**ADDR_BITS words.
- READ_MODE, 0, port A same-address behaviour: 0 = read-first (old data), 1 = write-first (new merged data).
- OUT_REG, 0, 1 adds an output pipeline register to both read ports; read latency LAT = 1 + OUT_REG.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers except memory contents.
- a_en  in  1  port A access enable.
- a_we  in  DATA_WIDTH/8  byte write enables; bit i writes a_wdata[8i+7:8i].
- a_addr  in  ADDR_BITS  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  a_rdata updated this cycle.
- b_en  in  1  port B read enable; ignored while dump_busy.
- b_addr  in  ADDR_BITS  port B word address.
- b_rdata  out  DATA_WIDTH  port B read data.
- b_rvalid  out  1  b_rdata updated this cycle.
- dump_start  in  1  one-cycle request to stream the whole array.
- dump_busy  out  1  dump engine active; port B is owned by the engine.
- dump_valid  out  1  dump_addr/dump_data hold a word.
- dump_ready  in  1  consumer accepts the word when valid and ready are both high.
- dump_addr  out  ADDR_BITS  address of the presented word.
- dump_data  out  DATA_WIDTH  presented word.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values (async): a_rdata, b_rdata, dump_data, dump_addr = 0; all valid, busy and done flags = 0; FSM in IDLE; dump pointer = 0. Memory contents are untouched. Reset asserted mid-dump aborts the dump with no dump_done pulse.
- Port A timing: access accepted at edge N when a_en=1. a_rdata updates and a_rvalid=1 at edge N+LAT. Reads with a_we=0 and writes both return a word.
  - a_rvalid is 0 in every cycle without a matching access.
  - a_rdata holds its last value when no access completes.
- Port A write: only the bytes whose a_we bit is set are written; other bytes are retained.
  - READ_MODE=0: a_rdata returns the pre-write word.
  - READ_MODE=1: a_rdata returns the post-write merged word.
- Port B: same timing rules as port A with b_en/b_rvalid.
- Cross-port collision: a port B read of an address that port A writes in the same cycle returns the old word.
- Dump FSM states:
  - IDLE: dump_start=1 → ISSUE; ptr=0; dump_busy=1 from the next cycle.
  - ISSUE: drive a port B read of ptr for one cycle → WAIT.
  - WAIT: hold LAT cycles, counting from the issue edge → PRESENT.
  - PRESENT: dump_valid=1; dump_addr=ptr; dump_data = the word read. Data and address stay stable while dump_ready=0. On accept: if ptr == DEPTH-1 → DONE, else ptr+1 → ISSUE.
  - DONE: dump_done=1 for one cycle; dump_busy=0 → IDLE.
- dump_start is ignored while not in IDLE.
- Pointer wrap: ptr never exceeds DEPTH-1; the terminal check uses equality, not overflow.
- During a dump: b_en is ignored and b_rvalid=0. Port A remains fully usable. Each dumped word reflects memory at its own ISSUE cycle, so a port A write to an already-dumped address does not appear in the stream.
- Best-case dump throughput: one word per LAT+2 cycles.

Test Plan:
- Byte enables: write 0xDEADBEEF to addr 5 with a_we=4'b1111, then 0x000000AA with a_we=4'b0001, then read addr 5 → a_rdata = 0xDEADBEAA, a_rvalid=1 exactly 1 cycle after the read (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- Read mode: addr 3 holds 0x11111111; write 0x22222222 to addr 3 with a_en=1 → READ_MODE=0 returns 0x11111111, READ_MODE=1 returns 0x22222222.
- Collision: same cycle, port A writes 0x55 to addr 7 (old 0x44) and port B reads addr 7 → b_rdata = 0x44; a following port B read of addr 7 → 0x55.
- Dump with backpressure (ADDR_BITS=3): preload word i = i*0x10 for i=0..7; pulse dump_start; toggle dump_ready every other cycle → exactly 8 accepted beats with (addr, data) = (i, i*0x10) in order. dump_data stays stable while stalled. dump_done pulses once after beat 7; dump_busy then drops. b_en pulses during the dump yield b_rvalid=0.
- Reset mid-dump: assert reset during the PRESENT state of word 3 → dump_valid, dump_busy and a_rvalid go 0 immediately with no dump_done. A new dump_start after reset restarts at addr 0, and memory contents are intact.
- dump_start while busy: second pulse at word 2 → ignored; exactly DEPTH beats and a single dump_done.
